// File: rtl/tick_scheduler.sv
// tick_scheduler: shared-prescaler clock-enable scheduler. It produces one-cycle
// enable strobes for up to NCH channels, each at its own multiple of the base tick.
// Optional build macro: TICK_SCHED_SYNC_EN. When it is defined, an APPLY that starts
// a channel also clears the prescaler, so the new channel's first tick is phase-aligned.
//
// Config FSM
//   state   | meaning
//   S_IDLE  | cfg_ready high, waiting for a configuration transfer
//   S_APPLY | captured transfer is written into the target channel
module tick_scheduler #(
  parameter int  PRESCALE = 2200,
  parameter int  NCH      = 4,
  parameter int  CW       = 8,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_run,
  output logic           base_tick,
  output logic [NCH-1:0] tick_en,
  output logic [NCH-1:0] busy
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic {S_IDLE, S_APPLY} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CW-1:0]  per_cap_q, per_cap_d;
  logic           run_q, run_d;

  logic [PW-1:0]  pcnt_q, pcnt_d;
  logic           pre_tick;
  logic           pre_tick_eff;

  logic           base_tick_q, base_tick_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] busy_q, busy_d;
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];

  assign pre_tick = (pcnt_q == PW'(PRESCALE - 1));

`ifdef TICK_SCHED_SYNC_EN
  localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);
  logic sync_clr;

  // A start of an in-range channel re-phases the prescaler and swallows this cycle's pre_tick
  always_comb begin
    sync_clr     = (state_q == S_APPLY) && run_q && (per_cap_q != '0) && ({1'b0, ch_q} < NCH_W);
    pre_tick_eff = pre_tick && !sync_clr;
    pcnt_d       = (sync_clr || pre_tick) ? '0 : pcnt_q + PW'(1);
  end
`else
  // Free-running prescaler, never touched by configuration
  always_comb begin
    pre_tick_eff = pre_tick;
    pcnt_d       = pre_tick ? '0 : pcnt_q + PW'(1);
  end
`endif

  // Config FSM next state and capture of the accepted transfer
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    per_cap_d = per_cap_q;
    run_d     = run_q;
    cfg_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_d   = S_APPLY;
          ch_d      = cfg_ch;
          per_cap_d = cfg_period;
          run_d     = cfg_run;
        end
      end
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Channel counters: an APPLY write overrides any tick update of the same channel
  always_comb begin
    tick_d      = '0;
    busy_d      = busy_q;
    base_tick_d = pre_tick_eff;
    for (int i = 0; i < NCH; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      if ((state_q == S_APPLY) && (ch_q == CHW'(i))) begin
        period_d[i] = per_cap_q;
        if (run_q && (per_cap_q != '0)) begin
          cnt_d[i]  = per_cap_q - CW'(1);
          busy_d[i] = 1'b1;
        end else begin
          cnt_d[i]  = '0;
          busy_d[i] = 1'b0;
        end
      end else if (pre_tick_eff && busy_q[i]) begin
        if (cnt_q[i] == '0) begin
          tick_d[i] = 1'b1;
          cnt_d[i]  = period_q[i] - CW'(1);
        end else begin
          cnt_d[i]  = cnt_q[i] - CW'(1);
        end
      end
    end
  end

  // Prescaler and config FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      state_q   <= S_IDLE;
      ch_q      <= '0;
      per_cap_q <= '0;
      run_q     <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      state_q   <= state_d;
      ch_q      <= ch_d;
      per_cap_q <= per_cap_d;
      run_q     <= run_d;
    end
  end

  // Channel state and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_tick_q <= 1'b0;
      tick_q      <= '0;
      busy_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      base_tick_q <= base_tick_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  assign base_tick = base_tick_q;
  assign tick_en   = tick_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed vector table, hand-written corner sequences,
// and randomized traffic compared cycle by cycle against an event-count reference model.
module tb_tick_scheduler;

  localparam int PS  = 4;
  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic           cfg_run = 1'b0;
  logic           base_tick;
  logic [NCH-1:0] tick_en;
  logic [NCH-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  tick_scheduler #(.PRESCALE(PS), .NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_run    (cfg_run),
    .base_tick  (base_tick),
    .tick_en    (tick_en),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event at t=%0t", name, $time);
  endtask

  // Reference model: base ticks are numbered; a running channel ticks on the
  // base-tick numbers apply_number+P, +2P, ... ; prescaler phase is cycle arithmetic.
  int             m_t, m_npre, m_ch, m_p;
  bit             m_app, m_run, m_base;
  bit [NCH-1:0]   m_busy, m_tick;
  int             m_per  [NCH];
  int             m_next [NCH];

  always @(posedge clk or negedge rst_n) begin : model_step
    bit pre;
    bit sync;
    if (!rst_n) begin
      m_t = 0; m_npre = 0; m_ch = 0; m_p = 0;
      m_app = 0; m_run = 0; m_base = 0;
      m_busy = '0; m_tick = '0;
      for (int i = 0; i < NCH; i++) begin
        m_per[i] = 0;
        m_next[i] = 0;
      end
    end else begin
      pre  = ((m_t % PS) == PS - 1);
      sync = 0;
`ifdef TICK_SCHED_SYNC_EN
      sync = m_app && m_run && (m_p != 0) && (m_ch < NCH);
`endif
      if (sync) pre = 0;
      if (pre) m_npre++;
      m_tick = '0;
      for (int i = 0; i < NCH; i++) begin
        if (m_app && m_ch == i) begin
          m_per[i]  = m_p;
          m_busy[i] = m_run && (m_p != 0);
          m_next[i] = m_npre + m_p;
        end else if (pre && m_busy[i] && m_npre == m_next[i]) begin
          m_tick[i] = 1'b1;
          m_next[i] = m_next[i] + m_per[i];
        end
      end
      m_base = pre;
      m_t = sync ? 0 : m_t + 1;
      if (m_app) begin
        m_app = 0;
      end else if (cfg_valid) begin
        m_app = 1;
        m_ch  = int'(cfg_ch);
        m_p   = int'(cfg_period);
        m_run = cfg_run;
      end
    end
  end

  // Every cycle the DUT must match the model on all outputs
  always @(negedge clk) begin
    check("model_cycle", 32'({cfg_ready, base_tick, tick_en, busy}),
          32'({!m_app, m_base, m_tick, m_busy}));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input int ch, input int p, input bit run);
    bit done;
    done = 0;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_period = CW'(p); cfg_run = run;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      if (cfg_ready) done = 1;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    if (!done) timeout_fail("cfg_accept");
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  task automatic check_base_release();
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      check("base_after_rst", 32'(base_tick), 32'((e % 4) == 0));
    end
  endtask

  task automatic wait_base(output bit found);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (base_tick) found = 1;
    end
    if (!found) timeout_fail("wait_base_tick");
  endtask

  typedef struct {
    int             ch;
    int             p;
    bit             run;
    int             mon;
    logic [NCH-1:0] exp_busy;
    int             exp_ticks;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int  cnt;
    bit  found;
    int  t1 [$];
    int  t2 [$];
    int  first_base, first_tick;

    vecs[0] = '{0, 3,  1'b1, 0, 5'b00001, 4};
    vecs[1] = '{1, 2,  1'b1, 1, 5'b00011, 6};
    vecs[2] = '{2, 6,  1'b1, 2, 5'b00111, 2};
    vecs[3] = '{0, 0,  1'b1, 0, 5'b00110, 0};
    vecs[4] = '{1, 4,  1'b0, 1, 5'b00100, 0};
    vecs[5] = '{5, 1,  1'b1, 2, 5'b00100, 2};
    vecs[6] = '{4, 1,  1'b1, 4, 5'b10100, 12};
    vecs[7] = '{2, 12, 1'b1, 2, 5'b10100, 1};
    vecs[8] = '{4, 1,  1'b0, 4, 5'b00100, 0};

    // Reset values and first base ticks after release
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cfg_ready), 32'(1));
    check("rst_base", 32'(base_tick), 32'(0));
    check("rst_tick", 32'(tick_en), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    #2 rst_n = 1'b1;
    check_base_release();

    // Vector table: write, check busy, count target-channel ticks over 48 cycles
    foreach (vecs[i]) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      cfg_write(vecs[i].ch, vecs[i].p, vecs[i].run);
      cnt = 0;
      for (int n = 0; n <= 49; n++) begin
        @(negedge clk);
        if (n == 1) check("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
        if (n >= 2 && tick_en[vecs[i].mon]) cnt++;
      end
      check("vec_ticks", cnt, vecs[i].exp_ticks);
    end

    // Asynchronous reset while ch0 strobes
    cfg_write(0, 1, 1'b1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (tick_en[0]) found = 1;
    end
    if (!found) timeout_fail("wait_tick0");
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tick", 32'(tick_en), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_base", 32'(base_tick), 32'(0));
    check("midrst_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk); #3 rst_n = 1'b1;
    check_base_release();

    // Reset during APPLY discards the captured transfer
    cfg_write(1, 2, 1'b1);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("apply_rst_busy", 32'(busy), 32'(0));
    check("apply_rst_ready", 32'(cfg_ready), 32'(1));

    // Back-to-back transfers with cfg_valid held
    do_reset();
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_period = 8'd2; cfg_run = 1'b1;
    @(negedge clk); check("b2b_ready0", 32'(cfg_ready), 32'(1));
    @(posedge clk); #1 cfg_ch = 3'd2; cfg_period = 8'd5;
    @(negedge clk); check("b2b_ready1", 32'(cfg_ready), 32'(0));
    @(posedge clk); #1;
    @(negedge clk); check("b2b_ready2", 32'(cfg_ready), 32'(1));
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk); check("b2b_ready3", 32'(cfg_ready), 32'(0));
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (tick_en[1]) t1.push_back(n);
      if (tick_en[2]) t2.push_back(n);
    end
    if (t1.size() >= 3) begin
      check("b2b_gap_ch1a", t1[1] - t1[0], 8);
      check("b2b_gap_ch1b", t1[2] - t1[1], 8);
    end else timeout_fail("b2b_ch1_pulses");
    if (t2.size() >= 2) check("b2b_gap_ch2", t2[1] - t2[0], 20);
    else timeout_fail("b2b_ch2_pulses");
    check("b2b_busy", 32'(busy), 32'(5'b00110));

    // APPLY of running ch0 lands on a pre_tick cycle
    do_reset();
    cfg_write(0, 1, 1'b1);
    wait_base(found);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_period = 8'd1; cfg_run = 1'b1;
    @(negedge clk); check("coll_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("coll_no_tick", 32'(tick_en[0]), 32'(0));
`ifdef TICK_SCHED_SYNC_EN
    check("coll_base", 32'(base_tick), 32'(0));
`else
    check("coll_base", 32'(base_tick), 32'(1));
`endif
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("coll_next_tick", 32'(tick_en[0]), 32'(1));
    check("coll_next_base", 32'(base_tick), 32'(1));

    // Start ch3 P=2 when the prescaler phase is 2 in the APPLY cycle
    do_reset();
    wait_base(found);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_period = 8'd2; cfg_run = 1'b1;
    @(posedge clk); #1 cfg_valid = 1'b0;
    first_base = -1;
    first_tick = -1;
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      if (n > 0 && base_tick && first_base < 0) first_base = n;
      if (tick_en[3] && first_tick < 0) first_tick = n;
    end
`ifdef TICK_SCHED_SYNC_EN
    check("sync_first_base", first_base, 5);
    check("sync_first_tick", first_tick, 9);
`else
    check("sync_first_base", first_base, 2);
    check("sync_first_tick", first_tick, 6);
`endif

    // Randomized traffic, checked by the per-cycle model comparison
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_ch     = CHW'($urandom_range(0, 7));
      cfg_period = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255))
                                               : CW'($urandom_range(0, 6));
      cfg_run    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    cfg_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
